// File: rtl/pc_defs_pkg.sv
// Shared definitions for the PC / fetch-sequencing stage.
// Holds the state encoding, the EBREAK opcode and the default PC width.
package pc_defs;

    // Default PC width; matches the instruction memory address input.
    localparam int PC_WIDTH_DEF = 10;

    // Fetch sequencer states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;
    localparam logic [1:0] ST_TRAP = 2'd3;

    // EBREAK instruction word; fetching it halts the sequencer.
    localparam logic [31:0] EBREAK_OPCODE = 32'h00100073;

    // Instruction fetch addresses must be word aligned.
    function automatic logic is_word_aligned(input logic [1:0] lsbs);
        return (lsbs == 2'b00);
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection for pc_fetch_unit.
// Ports: pc, jump/jump_target, branch_taken/branch_target in;
//        pc_plus4, target, redirect, misaligned out.
module next_pc_mux
    import pc_defs::*;
#(
    parameter int PC_WIDTH = PC_WIDTH_DEF
) (
    input  logic [PC_WIDTH-1:0] pc,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    output logic [PC_WIDTH-1:0] pc_plus4,
    output logic [PC_WIDTH-1:0] target,
    output logic                redirect,
    output logic                misaligned
);

    // Wraps modulo 2^PC_WIDTH with no carry out.
    assign pc_plus4 = pc + PC_WIDTH'(4);

    // Jump outranks branch when both are requested.
    always_comb begin
        target   = pc_plus4;
        redirect = 1'b0;
        if (jump) begin
            target   = jump_target;
            redirect = 1'b1;
        end else if (branch_taken) begin
            target   = branch_target;
            redirect = 1'b1;
        end
    end

    assign misaligned = redirect && !is_word_aligned(target[1:0]);

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer feeding instruction memory.
// Ports: clk, reset, stall, branch/jump redirects, resume, Instruction_Code in;
//        PC, PC_plus4, fetch_valid, halted, misaligned_trap, trap_addr,
//        fetch_count out.
module pc_fetch_unit
    import pc_defs::*;
#(
    parameter int                   PC_WIDTH     = PC_WIDTH_DEF,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = '0,
    parameter logic [31:0]          HALT_OPCODE  = EBREAK_OPCODE,
    parameter int                   COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [PC_WIDTH-1:0]    branch_target,
    input  logic                   jump,
    input  logic [PC_WIDTH-1:0]    jump_target,
    input  logic                   resume,
    input  logic [31:0]            Instruction_Code,
    output logic [PC_WIDTH-1:0]    PC,
    output logic [PC_WIDTH-1:0]    PC_plus4,
    output logic                   fetch_valid,
    output logic                   halted,
    output logic                   misaligned_trap,
    output logic [PC_WIDTH-1:0]    trap_addr,
    output logic [COUNT_WIDTH-1:0] fetch_count
);

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [PC_WIDTH-1:0]    pc_nxt;
    logic [PC_WIDTH-1:0]    trap_nxt;
    logic [PC_WIDTH-1:0]    target;
    logic                   redirect;
    logic                   misaligned;
    logic                   hit_halt;
    logic                   advance;
    logic [COUNT_WIDTH-1:0] count_nxt;

    next_pc_mux #(
        .PC_WIDTH (PC_WIDTH)
    ) u_mux (
        .pc            (PC),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_plus4      (PC_plus4),
        .target        (target),
        .redirect      (redirect),
        .misaligned    (misaligned)
    );

    // A stalled slot may hold a stale word, so EBREAK only counts unstalled.
    assign hit_halt = (Instruction_Code == HALT_OPCODE) && !stall;

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        trap_nxt  = trap_addr;
        advance   = 1'b0;
        case (state)
            ST_IDLE: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (hit_halt) begin
                    state_nxt = ST_HALT;
                end else if (redirect) begin
                    // Redirects win over stall so none is ever lost.
                    if (misaligned) begin
                        state_nxt = ST_TRAP;
                        trap_nxt  = target;
                    end else begin
                        pc_nxt  = target;
                        advance = 1'b1;
                    end
                end else if (!stall) begin
                    pc_nxt  = PC_plus4;
                    advance = 1'b1;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = PC_plus4;
                    advance   = 1'b1;
                end
            end
            default: begin
                // TRAP is sticky until reset.
                state_nxt = state;
            end
        endcase
    end

    // Saturating counter: sticks at all-ones instead of wrapping.
    always_comb begin
        count_nxt = fetch_count;
        if (advance && (fetch_count != '1)) begin
            count_nxt = fetch_count + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            PC          <= RESET_VECTOR;
            trap_addr   <= '0;
            fetch_count <= '0;
        end else begin
            state       <= state_nxt;
            PC          <= pc_nxt;
            trap_addr   <= trap_nxt;
            fetch_count <= count_nxt;
        end
    end

    assign fetch_valid     = (state == ST_RUN);
    assign halted          = (state == ST_HALT);
    assign misaligned_trap = (state == ST_TRAP);

endmodule
